cva6_clic_arbiter: RTL and testbench
====================================

# cva6_clic_arbiter

CLIC-style interrupt arbiter feeding the CVA6 core's interrupt interface: irq onehot, level, shv and ack. It collects up to NumInterruptSrc sources, tracks edge- or level-triggered pending state per source, and picks the highest-level enabled source above the machine threshold. It presents that source to the core with a stable hold/ack handshake. On acknowledge it clears edge-pending state, and it withdraws or preempts a presented interrupt when a higher-level source arrives or the presented source stops qualifying.

## Interface
- NumInterruptSrc, 256: number of sources; source index 0..N-1.
- IdWidth, $clog2(NumInterruptSrc): width of the source index.
- clk_i  in  1  core clock; single clock domain.
- rst_ni  in  1  reset, asynchronous, active-low.
- src_i  in  N  raw interrupt lines, synchronous to clk_i.
- src_en_i  in  N  per-source enable.
- src_edge_i  in  N  1 = rising-edge triggered, 0 = level triggered.
- src_shv_i  in  N  per-source selective hardware vectoring.
- src_level_i  in  8*N  per-source level; source i uses bits [8i+7:8i].
- mth_i  in  8  machine interrupt threshold.
- irq_o  out  N  onehot presented interrupt; all-zero = none.
- irq_level_o  out  8  level of presented interrupt.
- irq_shv_o  out  1  shv bit of presented interrupt.
- irq_id_o  out  IdWidth  index of presented interrupt; 0 when none.
- irq_ack_i  in  1  single-cycle core acknowledge of the presented interrupt.

## Operation
- Pending stage, per source:
  - src_q holds src_i delayed one cycle.
  - Edge mode: pend_q is set on src_i & ~src_q and cleared on ack of that source. Set and clear in the same cycle: set wins.
  - Level mode: pend_q = src_i registered; ack has no effect on it.
  - Changing src_edge_i clears pend_q of that source.
- Eligibility:
  - A source is eligible when pend_q & src_en_i & (level > mth_i).
  - Level 0 is never eligible.
- Arbiter:
  - Combinational max-level search over eligible sources; on equal levels the lowest index wins.
  - The result is registered into win_q (valid, id, level, shv) every cycle.
  - In the cycle irq_ack_i is accepted, win_q loads invalid.
- FSM states: IDLE, PRESENT.
- IDLE:
  - irq_o = 0, irq_level_o = 0, irq_shv_o = 0, irq_id_o = 0.
  - If win_q.valid and the source still qualifies (pend_q[id], src_en_i[id], level > mth_i), load the output registers from win_q and go to PRESENT.
- PRESENT: outputs held stable. Priority order:
  - (1) irq_ack_i: clear pend_q[id] if that source is edge-triggered; outputs go to zero; go to IDLE.
  - (2) Withdraw, any of: pend_q[id]=0; src_en_i[id]=0; irq_level_o <= mth_i; win_q.valid with win_q.level > irq_level_o. On withdraw, outputs go to zero and the FSM goes to IDLE; pend_q is untouched.
  - (3) Otherwise hold.
- Ack in the same cycle as a withdraw condition: ack wins. The core has taken the interrupt.
- irq_ack_i in IDLE is ignored and must not clear any pend_q.
- irq_o always has at most one bit set and always equals onehot(irq_id_o) when non-zero.

## Timing
- Reset (async assert, synchronous-release usage): all outputs 0, FSM IDLE, pend_q/src_q/win_q cleared. Reset asserted mid-PRESENT drops irq_o immediately.
- Edge source rising in cycle 0:
  - pend_q visible cycle 1.
  - win_q visible cycle 2.
  - irq_o visible cycle 3 (latency 3).
- Ack in cycle a:
  - irq_o = 0 in cycles a+1 and a+2.
  - Next presentation earliest in cycle a+3.
- Withdraw decided in cycle w:
  - irq_o = 0 in cycle w+1.
  - Replacement presented earliest in cycle w+2.
- Preemption: a higher-level source rising in cycle 0 while another is PRESENT:
  - Old interrupt withdrawn at the end of cycle 2.
  - New one presented in cycle 4.
- Outputs are flop-driven, with no combinational path from any input to any output.

## Test plan
- Reset: hold rst_ni=0, src_i all ones, src_en_i all ones -> irq_o=0, irq_level_o=0, irq_id_o=0. After release, no spurious edge pending from power-up.
- Single edge: src_edge_i[5]=1, level 8'h40, mth_i=0; pulse src_i[5] one cycle at cycle 0 -> irq_o=1<<5, irq_id_o=5, irq_level_o=8'h40 from cycle 3, held until ack. Ack at cycle 7 -> irq_o=0 from cycle 8 and no re-presentation.
- Tie and threshold:
  - Sources 3 and 9 at level 8'h20, source 1 at 8'h10, mth_i=8'h10 -> id 3 presented first; source 1 is never presented.
  - After ack of 3, id 9 is presented 3 cycles after the ack.
- Preemption: level source 2 (8'h30) presented; raise edge source 7 (8'h80) in cycle 0 -> irq_o=0 in cycle 3, irq_o=1<<7 in cycle 4. After ack of 7, source 2 is re-presented.
- Withdraw/ack collision:
  - Level source drops in the same cycle as irq_ack_i -> ack wins, FSM IDLE, no error.
  - Edge re-trigger coinciding with ack -> pend_q stays set and the source is re-presented at ack+3.
- Mid-operation reset: assert rst_ni while PRESENT -> irq_o=0 before the next clock edge, all pending cleared. After release, only new edges are presented.

Source files
------------

// File: rtl/cva6_clic_arbiter.sv
// -----------------------------------------------------------------------------
// cva6_clic_arbiter
//   CLIC-style interrupt arbiter for the CVA6 interrupt interface. Each source
//   keeps an edge- or level-triggered pending bit. The highest-level eligible
//   source above the machine threshold is selected, registered, and presented
//   to the core through a hold/ack handshake. A presented interrupt is
//   withdrawn when it stops qualifying or a higher-level winner appears.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   src_i               raw interrupt lines (synchronous to clk_i)
//   src_en_i            per-source enable
//   src_edge_i          1 = rising-edge triggered, 0 = level triggered
//   src_shv_i           per-source selective hardware vectoring bit
//   src_level_i         per-source 8-bit level, source i at [8i+7:8i]
//   mth_i               machine interrupt threshold
//   irq_o               onehot presented interrupt (zero = none)
//   irq_level_o         level of the presented interrupt
//   irq_shv_o           shv bit of the presented interrupt
//   irq_id_o            index of the presented interrupt (0 = none)
//   irq_ack_i           single-cycle core acknowledge
//
// All outputs are driven directly from flops.
// -----------------------------------------------------------------------------

// Per-source pending bit.
//   i_arm   low for the first cycle after reset so a line that was already
//           high while in reset is not mistaken for a rising edge
//   i_clr   acknowledge of this source (only affects edge mode)
module cva6_clic_pend_cell (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_arm,
    input  logic i_src,
    input  logic i_edge,
    input  logic i_clr,
    output logic o_pend
);

    logic r_src;
    logic r_edge;
    logic r_pend;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_src  <= 1'b0;
            r_edge <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_src  <= i_src;
            r_edge <= i_edge;
            if (i_edge != r_edge) begin
                // Trigger-mode change invalidates whatever was pending.
                r_pend <= 1'b0;
            end else if (i_edge) begin
                // A new rising edge beats a simultaneous acknowledge.
                if (i_arm && i_src && !r_src) begin
                    r_pend <= 1'b1;
                end else if (i_clr) begin
                    r_pend <= 1'b0;
                end
            end else begin
                r_pend <= i_src;
            end
        end
    end

    assign o_pend = r_pend;

endmodule

module cva6_clic_arbiter #(
    parameter int unsigned NumInterruptSrc = 256,
    parameter int unsigned IdWidth         = $clog2(NumInterruptSrc)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumInterruptSrc-1:0]   src_i,
    input  logic [NumInterruptSrc-1:0]   src_en_i,
    input  logic [NumInterruptSrc-1:0]   src_edge_i,
    input  logic [NumInterruptSrc-1:0]   src_shv_i,
    input  logic [8*NumInterruptSrc-1:0] src_level_i,
    input  logic [7:0]                   mth_i,
    output logic [NumInterruptSrc-1:0]   irq_o,
    output logic [7:0]                   irq_level_o,
    output logic                         irq_shv_o,
    output logic [IdWidth-1:0]           irq_id_o,
    input  logic                         irq_ack_i
);

    localparam int unsigned N = NumInterruptSrc;

    typedef struct packed {
        logic               valid;
        logic [IdWidth-1:0] id;
        logic [7:0]         level;
        logic               shv;
    } win_t;

    typedef enum logic {
        IDLE,
        PRESENT
    } state_e;

    logic               r_arm;
    logic [N-1:0]       w_pend;
    logic [N-1:0]       w_elig;
    logic [N-1:0]       w_clr;
    logic [N-1:0][7:0]  w_lvl;
    win_t               w_best;
    win_t               r_win;
    logic               w_ack_fire;
    logic               w_withdraw;

    state_e             r_state;
    state_e             w_state_d;
    logic [N-1:0]       r_irq;
    logic [N-1:0]       w_irq_d;
    logic [IdWidth-1:0] r_id;
    logic [IdWidth-1:0] w_id_d;
    logic [7:0]         r_level;
    logic [7:0]         w_level_d;
    logic               r_shv;
    logic               w_shv_d;

    assign w_lvl      = src_level_i;
    assign w_ack_fire = (r_state == PRESENT) && irq_ack_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_arm <= 1'b0;
        else         r_arm <= 1'b1;
    end

    // ---------------------------------------------------------------------
    // Pending stage and eligibility
    // ---------------------------------------------------------------------
    for (genvar gi = 0; gi < N; gi++) begin : g_src
        assign w_clr[gi]  = w_ack_fire && (r_id == IdWidth'(gi));
        // Level 0 can never exceed the threshold, so it is never eligible.
        assign w_elig[gi] = w_pend[gi] && src_en_i[gi] && (w_lvl[gi] > mth_i);

        cva6_clic_pend_cell u_cell (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .i_arm  (r_arm),
            .i_src  (src_i[gi]),
            .i_edge (src_edge_i[gi]),
            .i_clr  (w_clr[gi]),
            .o_pend (w_pend[gi])
        );
    end

    // ---------------------------------------------------------------------
    // Max-level search; strict '>' keeps the lowest index on ties.
    // ---------------------------------------------------------------------
    always_comb begin
        w_best = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (w_elig[i] && (!w_best.valid || (w_lvl[i] > w_best.level))) begin
                w_best.valid = 1'b1;
                w_best.id    = IdWidth'(i);
                w_best.level = w_lvl[i];
                w_best.shv   = src_shv_i[i];
            end
        end
    end

    // The winner is dropped in the ack cycle: it was computed from pending
    // state that the ack is about to clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)         r_win <= '0;
        else if (w_ack_fire) r_win <= '0;
        else                 r_win <= w_best;
    end

    // ---------------------------------------------------------------------
    // Presentation FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_irq   <= '0;
            r_id    <= '0;
            r_level <= '0;
            r_shv   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_irq   <= w_irq_d;
            r_id    <= w_id_d;
            r_level <= w_level_d;
            r_shv   <= w_shv_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_irq_d    = r_irq;
        w_id_d     = r_id;
        w_level_d  = r_level;
        w_shv_d    = r_shv;
        w_withdraw = 1'b0;
        unique case (r_state)
            IDLE: begin
                // Recheck qualification: win_q is one cycle old.
                if (r_win.valid && w_elig[r_win.id]) begin
                    w_state_d          = PRESENT;
                    w_irq_d            = '0;
                    w_irq_d[r_win.id]  = 1'b1;
                    w_id_d             = r_win.id;
                    w_level_d          = r_win.level;
                    w_shv_d            = r_win.shv;
                end
            end
            PRESENT: begin
                w_withdraw = !w_pend[r_id] || !src_en_i[r_id] ||
                             (r_level <= mth_i) ||
                             (r_win.valid && (r_win.level > r_level));
                // Ack and withdraw both return to IDLE with zeroed outputs;
                // only the ack path clears edge pending (via w_clr).
                if (irq_ack_i || w_withdraw) begin
                    w_state_d = IDLE;
                    w_irq_d   = '0;
                    w_id_d    = '0;
                    w_level_d = '0;
                    w_shv_d   = 1'b0;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_irq_d   = '0;
                w_id_d    = '0;
                w_level_d = '0;
                w_shv_d   = 1'b0;
            end
        endcase
    end

    assign irq_o       = r_irq;
    assign irq_id_o    = r_id;
    assign irq_level_o = r_level;
    assign irq_shv_o   = r_shv;

endmodule

// File: tb/tb_cva6_clic_arbiter.sv
// Directed bench for cva6_clic_arbiter (16 sources). Inputs change 1 time unit
// after the rising edge; outputs are sampled in the same window. "Cycle 0" is
// the cycle a stimulus is applied, so it is seen at the following edge.
module tb_cva6_clic_arbiter;

    localparam int N  = 16;
    localparam int IW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      src, en, edg, shv;
    logic [N-1:0][7:0] lvl;
    logic [7:0]        mth;
    logic [N-1:0]      irq;
    logic [7:0]        irq_lvl;
    logic              irq_shv;
    logic [IW-1:0]     irq_id;
    logic              ack;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cva6_clic_arbiter #(.NumInterruptSrc(N)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .src_i       (src),
        .src_en_i    (en),
        .src_edge_i  (edg),
        .src_shv_i   (shv),
        .src_level_i (lvl),
        .mth_i       (mth),
        .irq_o       (irq),
        .irq_level_o (irq_lvl),
        .irq_shv_o   (irq_shv),
        .irq_id_o    (irq_id),
        .irq_ack_i   (ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src = '0; en = '1; edg = '0; shv = '0; lvl = '0; mth = '0; ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        src = '1; en = '1; edg = '1; shv = '1; mth = '0; ack = 1'b0;
        for (int i = 0; i < N; i++) lvl[i] = 8'h40;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (irq !== '0)     begin failures++; $display("FAIL reset_irq got=%h exp=0", irq); end
        checks++; if (irq_lvl !== '0) begin failures++; $display("FAIL reset_level got=%h exp=0", irq_lvl); end
        checks++; if (irq_id !== '0)  begin failures++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
        checks++; if (irq_shv !== 0)  begin failures++; $display("FAIL reset_shv got=%b exp=0", irq_shv); end
        rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            checks++;
            if (irq !== '0) begin failures++; $display("FAIL reset_no_spurious c=%0d irq=%h exp=0", c, irq); end
        end
        src = '0;
        tick();
    endtask

    task automatic test_single_edge();
        int eid; logic [N-1:0] e_irq; logic [IW-1:0] e_id; logic [7:0] e_lvl; logic e_shv;
        do_reset();
        edg[5] = 1'b1; lvl[5] = 8'h40; shv[5] = 1'b1;
        repeat (3) tick();
        src[5] = 1'b1;                              // cycle 0
        for (int c = 1; c <= 14; c++) begin
            tick();
            src[5] = 1'b0;
            ack = (c == 7);
            eid = (c >= 3 && c <= 7) ? 5 : -1;
            e_irq = '0; if (eid >= 0) e_irq[eid] = 1'b1;
            e_id  = (eid < 0) ? 4'd0 : 4'(eid);
            e_lvl = (eid < 0) ? 8'h00 : 8'h40;
            e_shv = (eid >= 0);
            checks++;
            if (irq !== e_irq || irq_id !== e_id || irq_lvl !== e_lvl || irq_shv !== e_shv) begin
                failures++;
                $display("FAIL single_edge c=%0d irq=%h id=%0d lvl=%h shv=%b exp irq=%h id=%0d lvl=%h shv=%b",
                         c, irq, irq_id, irq_lvl, irq_shv, e_irq, e_id, e_lvl, e_shv);
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_tie_threshold();
        int eid; logic [N-1:0] e_irq; logic [IW-1:0] e_id;
        do_reset();
        edg[1] = 1'b1; edg[3] = 1'b1; edg[9] = 1'b1;
        lvl[1] = 8'h10; lvl[3] = 8'h20; lvl[9] = 8'h20; mth = 8'h10;
        repeat (3) tick();
        src[1] = 1'b1; src[3] = 1'b1; src[9] = 1'b1;   // cycle 0
        for (int c = 1; c <= 14; c++) begin
            tick();
            src = '0;
            ack = (c == 3 || c == 6);
            eid = (c == 3) ? 3 : (c == 6) ? 9 : -1;
            e_irq = '0; if (eid >= 0) e_irq[eid] = 1'b1;
            e_id  = (eid < 0) ? 4'd0 : 4'(eid);
            checks++;
            if (irq !== e_irq || irq_id !== e_id || irq_lvl !== ((eid < 0) ? 8'h00 : 8'h20)) begin
                failures++;
                $display("FAIL tie_threshold c=%0d irq=%h id=%0d lvl=%h exp irq=%h id=%0d",
                         c, irq, irq_id, irq_lvl, e_irq, e_id);
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_preempt();
        int eid; logic [N-1:0] e_irq; logic [IW-1:0] e_id; logic [7:0] e_lvl;
        do_reset();
        edg[7] = 1'b1; lvl[2] = 8'h30; lvl[7] = 8'h80;
        repeat (2) tick();
        src[2] = 1'b1;
        repeat (5) tick();
        checks++;
        if (irq !== 16'h0004 || irq_id !== 4'd2 || irq_lvl !== 8'h30) begin
            failures++; $display("FAIL preempt_initial irq=%h id=%0d lvl=%h exp irq=0004 id=2 lvl=30", irq, irq_id, irq_lvl);
        end
        src[7] = 1'b1;                              // cycle 0
        for (int c = 1; c <= 9; c++) begin
            tick();
            src[7] = 1'b0;
            ack = (c == 4);
            eid = (c <= 2) ? 2 : (c == 4) ? 7 : (c >= 7) ? 2 : -1;
            e_irq = '0; if (eid >= 0) e_irq[eid] = 1'b1;
            e_id  = (eid < 0) ? 4'd0 : 4'(eid);
            e_lvl = (eid < 0) ? 8'h00 : (eid == 7) ? 8'h80 : 8'h30;
            checks++;
            if (irq !== e_irq || irq_id !== e_id || irq_lvl !== e_lvl) begin
                failures++;
                $display("FAIL preempt c=%0d irq=%h id=%0d lvl=%h exp irq=%h id=%0d lvl=%h",
                         c, irq, irq_id, irq_lvl, e_irq, e_id, e_lvl);
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_collision_level();
        do_reset();
        lvl[2] = 8'h30;
        tick();
        src[2] = 1'b1;
        repeat (4) tick();
        src[2] = 1'b0;                              // pending drops next cycle
        tick();
        ack = 1'b1;                                 // ack with withdraw pending
        checks++;
        if (irq !== 16'h0004 || irq_id !== 4'd2) begin
            failures++; $display("FAIL collision_level_held irq=%h id=%0d exp irq=0004 id=2", irq, irq_id);
        end
        for (int c = 1; c <= 5; c++) begin
            tick();
            ack = 1'b0;
            checks++;
            if (irq !== '0 || irq_id !== '0 || irq_lvl !== '0) begin
                failures++; $display("FAIL collision_level c=%0d irq=%h id=%0d lvl=%h exp all 0", c, irq, irq_id, irq_lvl);
            end
        end
    endtask

    task automatic test_ack_retrigger();
        int eid; logic [N-1:0] e_irq;
        do_reset();
        edg[5] = 1'b1; lvl[5] = 8'h40;
        repeat (3) tick();
        src[5] = 1'b1;                              // cycle 0
        for (int c = 1; c <= 11; c++) begin
            tick();
            src[5] = (c == 3);                      // re-trigger together with ack
            ack    = (c == 3 || c == 6);
            eid = (c == 3 || c == 6) ? 5 : -1;
            e_irq = '0; if (eid >= 0) e_irq[eid] = 1'b1;
            checks++;
            if (irq !== e_irq || irq_id !== ((eid < 0) ? 4'd0 : 4'd5)) begin
                failures++; $display("FAIL ack_retrigger c=%0d irq=%h id=%0d exp irq=%h", c, irq, irq_id, e_irq);
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_withdraw();
        int eid; logic [N-1:0] e_irq;
        do_reset();
        edg[5] = 1'b1; lvl[5] = 8'h40;
        repeat (3) tick();
        src[5] = 1'b1;                              // cycle 0
        for (int c = 1; c <= 12; c++) begin
            tick();
            src[5] = 1'b0;
            en[5]  = (c != 4);                      // one-cycle disable
            if (c == 9) mth = 8'h40;                // level no longer above threshold
            eid = ((c >= 3 && c <= 4) || (c >= 7 && c <= 9)) ? 5 : -1;
            e_irq = '0; if (eid >= 0) e_irq[eid] = 1'b1;
            checks++;
            if (irq !== e_irq || irq_lvl !== ((eid < 0) ? 8'h00 : 8'h40)) begin
                failures++; $display("FAIL withdraw c=%0d irq=%h lvl=%h exp irq=%h", c, irq, irq_lvl, e_irq);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        edg[5] = 1'b1; edg[9] = 1'b1; lvl[5] = 8'h40; lvl[9] = 8'h20;
        repeat (3) tick();
        src[5] = 1'b1; src[9] = 1'b1;               // cycle 0; source 9 stays high
        repeat (3) begin
            tick();
            src[5] = 1'b0;
        end
        checks++;
        if (irq !== 16'h0020) begin failures++; $display("FAIL midreset_present irq=%h exp=0020", irq); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (irq !== '0 || irq_id !== '0 || irq_lvl !== '0) begin
            failures++; $display("FAIL midreset_async irq=%h id=%0d lvl=%h exp all 0", irq, irq_id, irq_lvl);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            checks++;
            if (irq !== '0) begin failures++; $display("FAIL midreset_cleared c=%0d irq=%h exp=0", c, irq); end
        end
        src[5] = 1'b1;                              // fresh edge, cycle 0
        for (int c = 1; c <= 4; c++) begin
            tick();
            src[5] = 1'b0;
            checks++;
            if (irq !== ((c >= 3) ? 16'h0020 : 16'h0000)) begin
                failures++; $display("FAIL midreset_new_edge c=%0d irq=%h exp=%h", c, irq, (c >= 3) ? 16'h0020 : 16'h0000);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_tie_threshold();
        test_preempt();
        test_collision_level();
        test_ack_retrigger();
        test_withdraw();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
